// File: rtl/result_collector.sv
// Round-robin return path from the encrypter bank to the QSPI host, streaming each word MS nibble first.
// Optional WAIT_RESULT watchdog is compiled in with `define COLLECTOR_TIMEOUT_EN.
module result_collector #(
    parameter int NUM_ENCRYPTERS  = 4,
    parameter int ENCRYPTER_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      enable,
    input  logic [NUM_ENCRYPTERS*ENCRYPTER_WIDTH-1:0] enc_result_data,
    input  logic [NUM_ENCRYPTERS-1:0]                 enc_result_valid,
    output logic [NUM_ENCRYPTERS-1:0]                 enc_result_ack,
    output logic [3:0]                                qspi_out_data,
    output logic                                      qspi_out_valid,
    input  logic                                      qspi_out_ready,
    output logic                                      busy,
    output logic [15:0]                               packet_count,
    output logic                                      timeout
);

    localparam int NIBBLES = ENCRYPTER_WIDTH / 4;
    localparam int IDX_W   = (NUM_ENCRYPTERS > 1) ? $clog2(NUM_ENCRYPTERS) : 1;
    localparam int NIB_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] WAIT_RESULT = 2'd1;
    localparam logic [1:0] SHIFT       = 2'd2;

    logic [1:0]                  state;
    logic [IDX_W-1:0]            idx;
    logic [IDX_W-1:0]            idx_next;
    logic [NIB_W-1:0]            nib_cnt;
    logic [ENCRYPTER_WIDTH-1:0]  shift_reg;
    logic [ENCRYPTER_WIDTH-1:0]  sel_data;
    logic                        sel_valid;
    logic                        out_valid;
    logic [NUM_ENCRYPTERS-1:0]   ack_reg;
    logic [15:0]                 pkt_cnt;
    logic                        timer_hit;
    logic                        timeout_flag;

    // Only the encrypter whose turn it is can be observed; others wait their turn.
    assign sel_valid = enc_result_valid[idx];
    assign sel_data  = enc_result_data[int'(idx)*ENCRYPTER_WIDTH +: ENCRYPTER_WIDTH];
    assign idx_next  = (idx == IDX_W'(NUM_ENCRYPTERS - 1)) ? '0 : idx + 1'b1;

`ifdef COLLECTOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;

    assign timer_hit = (state == WAIT_RESULT) && !sel_valid &&
                       (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Counter is held at zero outside WAIT_RESULT, so every entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else if (state != WAIT_RESULT) begin
            wait_cnt <= '0;
        end else if (!sel_valid) begin
            if (timer_hit)
                timeout_flag <= 1'b1;
            else
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timer_hit    = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            nib_cnt   <= '0;
            shift_reg <= '0;
            out_valid <= 1'b0;
            ack_reg   <= '0;
            pkt_cnt   <= '0;
        end else begin
            ack_reg <= '0;
            case (state)
                IDLE: begin
                    if (enable && !timeout_flag) begin
                        state <= WAIT_RESULT;
                        idx   <= '0;
                    end
                end
                WAIT_RESULT: begin
                    // A ready result beats a falling enable: the word is still collected.
                    if (sel_valid) begin
                        shift_reg    <= sel_data;
                        ack_reg[idx] <= 1'b1;
                        nib_cnt      <= NIB_W'(NIBBLES - 1);
                        out_valid    <= 1'b1;
                        state        <= SHIFT;
                    end else if (!enable || timer_hit) begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (qspi_out_ready) begin
                        shift_reg <= shift_reg << 4;
                        if (nib_cnt == '0) begin
                            out_valid <= 1'b0;
                            pkt_cnt   <= pkt_cnt + 16'd1;
                            idx       <= idx_next;
                            state     <= enable ? WAIT_RESULT : IDLE;
                        end else begin
                            nib_cnt <= nib_cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign enc_result_ack = ack_reg;
    assign qspi_out_data  = shift_reg[ENCRYPTER_WIDTH-1 -: 4];
    assign qspi_out_valid = out_valid;
    assign busy           = (state != IDLE);
    assign packet_count   = pkt_cnt;
    assign timeout        = timeout_flag;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: ordering, wrap, backpressure, drain, reset abort and watchdog.
module tb_result_collector;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [127:0] enc_data;
    logic [3:0]   enc_valid;
    logic [3:0]   enc_result_ack;
    logic [3:0]   qspi_out_data;
    logic         qspi_out_valid;
    logic         qspi_out_ready;
    logic         busy;
    logic [15:0]  packet_count;
    logic         timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0] nib_q[$];
    logic [3:0] ack_q[$];

    result_collector #(
        .NUM_ENCRYPTERS (4),
        .ENCRYPTER_WIDTH(32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .enc_result_data (enc_data),
        .enc_result_valid(enc_valid),
        .enc_result_ack  (enc_result_ack),
        .qspi_out_data   (qspi_out_data),
        .qspi_out_valid  (qspi_out_valid),
        .qspi_out_ready  (qspi_out_ready),
        .busy            (busy),
        .packet_count    (packet_count),
        .timeout         (timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic en, input logic rdy);
        enable         = en;
        qspi_out_ready = rdy;
    endtask

    task automatic raiseResult(input int k, input logic [31:0] word);
        enc_data[k*32 +: 32] = word;
        enc_valid[k]         = 1'b1;
    endtask

    task automatic doReset();
        reset     = 1'b0;
        enc_valid = 4'b0;
        applyStimulus(1'b0, 1'b1);
        nextCycle();
        nextCycle();
        reset = 1'b1;
        nib_q.delete();
        ack_q.delete();
    endtask

    task automatic waitPackets(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int'(packet_count) == target) break;
        end
        checkOutput(tag, 32'(packet_count), 32'(target));
    endtask

    task automatic waitAcks(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack_q.size() >= target) break;
        end
        checkOutput(tag, 32'(ack_q.size()), 32'(target));
    endtask

    function automatic logic [31:0] wordAt(input int k);
        logic [31:0] w = '0;
        for (int j = 0; j < 8; j++)
            if (k*8 + j < nib_q.size()) w = {w[27:0], nib_q[k*8 + j]};
        return w;
    endfunction

    function automatic logic [31:0] ackAt(input int k);
        return (k < ack_q.size()) ? 32'(ack_q[k]) : 32'hFFFF_FFFF;
    endfunction

    // Host and encrypter model: record accepted nibbles/acks, and drop a valid once it is acked.
    always @(negedge clk) begin
        if (reset && qspi_out_valid && qspi_out_ready) nib_q.push_back(qspi_out_data);
        if (|enc_result_ack) begin
            ack_q.push_back(enc_result_ack);
            checkOutput("ack_onehot", 32'($countones(enc_result_ack)), 32'd1);
            enc_valid = enc_valid & ~enc_result_ack;
        end
    end

    initial begin
        enc_data = '0;
        doReset();
        reset = 1'b0;
        nextCycle();
        @(negedge clk);
        checkOutput("rst_ack", 32'(enc_result_ack), 32'h0);
        checkOutput("rst_valid", 32'(qspi_out_valid), 32'h0);
        checkOutput("rst_data", 32'(qspi_out_data), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_pkt", 32'(packet_count), 32'h0);
        checkOutput("rst_timeout", 32'(timeout), 32'h0);

        // Order: results raised 3,1,0,2 must still leave as 0,1,2,3.
        doReset();
        applyStimulus(1'b1, 1'b1);
        raiseResult(3, 32'h4444_4444);
        repeat (4) nextCycle();
        @(negedge clk);
        checkOutput("ord_busy", 32'(busy), 32'h1);
        checkOutput("ord_no_out", 32'(qspi_out_valid), 32'h0);
        checkOutput("ord_no_ack", 32'(ack_q.size()), 32'h0);
        nextCycle();
        raiseResult(1, 32'h2222_2222);
        repeat (3) nextCycle();
        checkOutput("ord_still_no_ack", 32'(ack_q.size()), 32'h0);
        raiseResult(0, 32'h1111_1111);
        repeat (3) nextCycle();
        raiseResult(2, 32'h3333_3333);
        waitPackets(4, 200, "ord_pkt");
        checkOutput("ord_ack0", ackAt(0), 32'h1);
        checkOutput("ord_ack1", ackAt(1), 32'h2);
        checkOutput("ord_ack2", ackAt(2), 32'h4);
        checkOutput("ord_ack3", ackAt(3), 32'h8);
        checkOutput("ord_nibs", 32'(nib_q.size()), 32'd32);
        checkOutput("ord_w0", wordAt(0), 32'h1111_1111);
        checkOutput("ord_w1", wordAt(1), 32'h2222_2222);
        checkOutput("ord_w2", wordAt(2), 32'h3333_3333);
        checkOutput("ord_w3", wordAt(3), 32'h4444_4444);

        // Wrap: six sequential words, index returns to 0 after 3.
        doReset();
        applyStimulus(1'b1, 1'b1);
        raiseResult(0, 32'hA000_0000);
        raiseResult(1, 32'hA000_0001);
        raiseResult(2, 32'hA000_0002);
        raiseResult(3, 32'hA000_0003);
        waitPackets(2, 100, "wrap_pkt2");
        nextCycle();
        raiseResult(0, 32'hB000_0004);
        raiseResult(1, 32'hB000_0005);
        waitPackets(6, 200, "wrap_pkt6");
        checkOutput("wrap_ack4", ackAt(4), 32'h1);
        checkOutput("wrap_ack5", ackAt(5), 32'h2);
        checkOutput("wrap_w3", wordAt(3), 32'hA000_0003);
        checkOutput("wrap_w4", wordAt(4), 32'hB000_0004);
        checkOutput("wrap_w5", wordAt(5), 32'hB000_0005);
        nextCycle();
        raiseResult(3, 32'hC000_0003);
        repeat (5) nextCycle();
        checkOutput("wrap_idx_skip3", 32'(ack_q.size()), 32'd6);
        raiseResult(2, 32'hC000_0002);
        waitAcks(7, 20, "wrap_idx_acks");
        checkOutput("wrap_idx2", ackAt(6), 32'h4);

        // Backpressure: first-nibble latency, then nibble 5 held through a 3-cycle stall.
        doReset();
        applyStimulus(1'b1, 1'b1);
        nextCycle();
        raiseResult(0, 32'hA5C3_F00D);
        @(negedge clk);
        checkOutput("bp_pre_valid", 32'(qspi_out_valid), 32'h0);
        checkOutput("bp_pre_ack", 32'(enc_result_ack), 32'h0);
        @(negedge clk);
        checkOutput("bp_lat_ack", 32'(enc_result_ack), 32'h1);
        checkOutput("bp_lat_valid", 32'(qspi_out_valid), 32'h1);
        checkOutput("bp_lat_data", 32'(qspi_out_data), 32'hA);
        nextCycle();
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_data", 32'(qspi_out_data), 32'h5);
            checkOutput("bp_hold_valid", 32'(qspi_out_valid), 32'h1);
        end
        nextCycle();
        applyStimulus(1'b1, 1'b1);
        waitPackets(1, 50, "bp_pkt");
        checkOutput("bp_nibs", 32'(nib_q.size()), 32'd8);
        checkOutput("bp_word", wordAt(0), 32'hA5C3_F00D);

        // Drain: enable falls after the second nibble, word still completes.
        doReset();
        applyStimulus(1'b1, 1'b1);
        nextCycle();
        raiseResult(0, 32'hDEAD_BEEF);
        for (int i = 0; i < 40; i++) begin
            nextCycle();
            if (nib_q.size() >= 2) break;
        end
        checkOutput("drain_2nib", 32'(nib_q.size()), 32'd2);
        applyStimulus(1'b0, 1'b1);
        raiseResult(1, 32'h0BAD_0BAD);
        waitPackets(1, 50, "drain_pkt");
        repeat (4) nextCycle();
        @(negedge clk);
        checkOutput("drain_busy", 32'(busy), 32'h0);
        checkOutput("drain_valid", 32'(qspi_out_valid), 32'h0);
        checkOutput("drain_acks", 32'(ack_q.size()), 32'd1);
        checkOutput("drain_nibs", 32'(nib_q.size()), 32'd8);
        checkOutput("drain_word", wordAt(0), 32'hDEAD_BEEF);

        // Reset mid-packet: abort after the third nibble, no count update.
        nextCycle();
        enc_valid = 4'b0;
        nib_q.delete();
        ack_q.delete();
        applyStimulus(1'b1, 1'b1);
        nextCycle();
        raiseResult(0, 32'h1234_5678);
        for (int i = 0; i < 40; i++) begin
            nextCycle();
            if (nib_q.size() >= 3) break;
        end
        checkOutput("rmid_3nib", 32'(nib_q.size()), 32'd3);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rmid_valid", 32'(qspi_out_valid), 32'h0);
        checkOutput("rmid_ack", 32'(enc_result_ack), 32'h0);
        checkOutput("rmid_busy", 32'(busy), 32'h0);
        checkOutput("rmid_pkt", 32'(packet_count), 32'h0);
        nextCycle();
        reset = 1'b1;
        ack_q.delete();
        nib_q.delete();
        raiseResult(1, 32'h5555_5555);
        raiseResult(0, 32'h6666_6666);
        waitAcks(1, 20, "rmid_restart");
        checkOutput("rmid_idx0", ackAt(0), 32'h1);

        // Watchdog: enable with nothing arriving.
        doReset();
        applyStimulus(1'b1, 1'b1);
`ifdef COLLECTOR_TIMEOUT_EN
        repeat (17) @(negedge clk);
        checkOutput("to_before", 32'(timeout), 32'h0);
        checkOutput("to_before_busy", 32'(busy), 32'h1);
        @(negedge clk);
        checkOutput("to_set", 32'(timeout), 32'h1);
        checkOutput("to_idle", 32'(busy), 32'h0);
        nextCycle();
        raiseResult(0, 32'h7777_7777);
        repeat (5) nextCycle();
        checkOutput("to_stuck_busy", 32'(busy), 32'h0);
        checkOutput("to_no_ack", 32'(ack_q.size()), 32'h0);
        checkOutput("to_sticky", 32'(timeout), 32'h1);
`else
        repeat (30) @(negedge clk);
        checkOutput("to_disabled", 32'(timeout), 32'h0);
        checkOutput("to_wait_forever", 32'(busy), 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
